// File: rtl/tt_mux_sel_seq_if.sv
// tt_mux_sel_seq_if: request handshake and status bundle between a requester and tt_mux_sel_seq.
interface tt_mux_sel_seq_if #(
    parameter int SEL_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_addr;
    logic             req_ena;
    logic             busy;
    logic             done;
    logic [SEL_W-1:0] cur_addr;
    logic             cur_valid;
    modport master (
        output req_valid, req_addr, req_ena,
        input  req_ready, busy, done, cur_addr, cur_valid
    );
    modport slave (
        input  req_valid, req_addr, req_ena,
        output req_ready, busy, done, cur_addr, cur_valid
    );
endinterface

// File: rtl/tt_mux_sel_seq.sv
// tt_mux_sel_seq: steps the mux controller select counter to a requested address (TT_MUX_SEL_SEQ_INCR_EN adds incremental stepping).
module tt_mux_sel_seq #(
    parameter int SEL_W   = 10,
    parameter int RST_CYC = 4,
    parameter int HALF    = 2,
    parameter int SETTLE  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    tt_mux_sel_seq_if.slave req,
    output logic            ctrl_sel_rst_n,
    output logic            ctrl_sel_inc,
    output logic            ctrl_ena
);
    localparam int CW = 16;
    localparam logic [CW-1:0] RST_LD  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
    localparam logic [CW-1:0] SET_LD  = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DIS, S_RST, S_INC_HI, S_INC_LO, S_SETTLE, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] n_q, n_d;
    logic [SEL_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0] cur_addr_q, cur_addr_d;
    logic             ena_q, ena_d;
    logic             cur_valid_q, cur_valid_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sel_rst_n_q, sel_rst_n_d;
    logic             inc_q, inc_d;
    logic             ctrl_ena_q, ctrl_ena_d;
    logic             last;
    logic             incr;
    logic [SEL_W-1:0] n_start;

    assign last = cnt_q == '0;
`ifdef TT_MUX_SEL_SEQ_INCR_EN
    assign incr = cur_valid_q && addr_q >= cur_addr_q;
`else
    assign incr = 1'b0;
`endif
    assign n_start = incr ? addr_q - cur_addr_q : addr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - CW'(1);
        n_d         = n_q;
        addr_d      = addr_q;
        ena_d       = ena_q;
        cur_addr_d  = cur_addr_q;
        cur_valid_d = cur_valid_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sel_rst_n_d = sel_rst_n_q;
        inc_d       = inc_q;
        ctrl_ena_d  = ctrl_ena_q;
        case (state_q)
            S_IDLE: if (req.req_valid && ready_q) begin
                state_d    = S_DIS;
                addr_d     = req.req_addr;
                ena_d      = req.req_ena;
                ready_d    = 1'b0;
                busy_d     = 1'b1;
                ctrl_ena_d = 1'b0;
            end
            S_DIS: begin
                n_d        = n_start;
                ctrl_ena_d = 1'b0;
                if (!incr) begin
                    state_d     = S_RST;
                    cnt_d       = RST_LD;
                    sel_rst_n_d = 1'b0;
                    cur_valid_d = 1'b0;
                end else begin
                    state_d = n_start == '0 ? S_SETTLE : S_INC_HI;
                    cnt_d   = n_start == '0 ? SET_LD : HALF_LD;
                    inc_d   = n_start != '0;
                end
            end
            S_RST: if (last) begin
                sel_rst_n_d = 1'b1;
                state_d     = n_q == '0 ? S_SETTLE : S_INC_HI;
                cnt_d       = n_q == '0 ? SET_LD : HALF_LD;
                inc_d       = n_q != '0;
            end
            S_INC_HI: if (last) begin
                state_d = S_INC_LO;
                cnt_d   = HALF_LD;
                inc_d   = 1'b0;
            end
            // the remote counter has advanced once the low half completes
            S_INC_LO: if (last) begin
                n_d     = n_q - SEL_W'(1);
                state_d = n_q == SEL_W'(1) ? S_SETTLE : S_INC_HI;
                cnt_d   = n_q == SEL_W'(1) ? SET_LD : HALF_LD;
                inc_d   = n_q != SEL_W'(1);
            end
            S_SETTLE: if (last) state_d = S_FIN;
            S_FIN: begin
                state_d     = S_IDLE;
                done_d      = 1'b1;
                ctrl_ena_d  = ena_q;
                cur_addr_d  = addr_q;
                cur_valid_d = 1'b1;
                busy_d      = 1'b0;
                ready_d     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            addr_q      <= '0;
            ena_q       <= 1'b0;
            cur_addr_q  <= '0;
            cur_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_rst_n_q <= 1'b0;
            inc_q       <= 1'b0;
            ctrl_ena_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            ena_q       <= ena_d;
            cur_addr_q  <= cur_addr_d;
            cur_valid_q <= cur_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sel_rst_n_q <= sel_rst_n_d;
            inc_q       <= inc_d;
            ctrl_ena_q  <= ctrl_ena_d;
        end
    end

    assign req.req_ready  = ready_q;
    assign req.busy       = busy_q;
    assign req.done       = done_q;
    assign req.cur_addr   = cur_addr_q;
    assign req.cur_valid  = cur_valid_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ctrl_ena_q;
endmodule

// File: tb/tb_tt_mux_sel_seq.sv
// tb_tt_mux_sel_seq: directed scoreboard bench with a ripple-counter model of the remote select counter.
module tb_tt_mux_sel_seq;
    localparam int SEL_W = 10;
    localparam int R     = 4;
    localparam int H     = 2;
    localparam int S     = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

    tt_mux_sel_seq_if #(.SEL_W(SEL_W)) bus();

    tt_mux_sel_seq #(.SEL_W(SEL_W), .RST_CYC(R), .HALF(H), .SETTLE(S)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(bus),
        .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .ctrl_sel_inc(ctrl_sel_inc),
        .ctrl_ena(ctrl_ena)
    );

    always #5 clk = ~clk;

    logic [SEL_W-1:0] model = '0;
    always @(posedge ctrl_sel_inc or negedge ctrl_sel_rst_n)
        if (!ctrl_sel_rst_n) model <= '0;
        else model <= model + 1'b1;

    logic inc_prev = 1'b0;
    int run = 0, rises = 0, seq_rises = 0, rst_low = 0, width_bad = 0, ena_bad = 0;
    always @(negedge clk) begin
        inc_prev  <= ctrl_sel_inc;
        run       <= (ctrl_sel_inc !== inc_prev) ? 1 : run + 1;
        seq_rises <= (bus.busy !== 1'b1) ? 0 : seq_rises + ((ctrl_sel_inc && !inc_prev) ? 1 : 0);
        if (ctrl_sel_inc && !inc_prev) rises <= rises + 1;
        if ((ctrl_sel_inc && !inc_prev && seq_rises > 0 && run != H) || (!ctrl_sel_inc && inc_prev && run != H))
            width_bad <= width_bad + 1;
        if (ctrl_sel_rst_n === 1'b0) rst_low <= rst_low + 1;
        if (ctrl_ena === 1'b1 && (ctrl_sel_inc === 1'b1 || ctrl_sel_rst_n === 1'b0)) ena_bad <= ena_bad + 1;
    end

    typedef struct {
        logic [SEL_W-1:0] addr;
        logic             ena;
        bit               full;
        int               n, lat, rlow, rise0, rlow0, wbad0, ebad0;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0;
    logic [SEL_W-1:0] m_cur = '0;
    bit m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [SEL_W-1:0] a, input logic e);
        exp_t x;
        int k;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_before_req", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_ena   = e;
        x.addr = a;
        x.ena  = e;
`ifdef TT_MUX_SEL_SEQ_INCR_EN
        x.full = !(m_valid && a >= m_cur);
`else
        x.full = 1'b1;
`endif
        x.n    = x.full ? int'(a) : int'(a - m_cur);
        x.lat  = 2 + (x.full ? R : 0) + 2 * H * x.n + S;
        x.rlow = x.full ? R + (m_valid ? 0 : 1) : 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        x.rise0 = rises;
        x.rlow0 = rst_low;
        x.wbad0 = width_bad;
        x.ebad0 = ena_bad;
        sb.push_back(x);
        chk("ena_low_after_hs", ctrl_ena, 0);
        chk("busy_after_hs", bus.busy, 1);
        chk("ready_after_hs", bus.req_ready, 0);
        chk("inc_quiet_after_hs", ctrl_sel_inc, 0);
        chk("rstn_quiet_after_hs", ctrl_sel_rst_n, m_valid);
    endtask

    task automatic finish(input bit wiggle);
        exp_t x;
        int cyc, rdy_busy;
        cyc = 0;
        rdy_busy = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (bus.req_ready === 1'b1 && bus.done !== 1'b1) rdy_busy++;
            bus.req_valid = wiggle && bus.done !== 1'b1 && cyc[0];
            if (wiggle) begin
                bus.req_addr = SEL_W'($urandom);
                bus.req_ena  = 1'($urandom);
            end
        end while (bus.done !== 1'b1 && cyc < 6000);
        bus.req_valid = 1'b0;
        x = sb.pop_front();
        chk("done_seen", bus.done, 1);
        if (x.full) chk("latency", cyc, x.lat);
        chk("ready_low_while_busy", rdy_busy, 0);
        chk("ena_final", ctrl_ena, x.ena);
        chk("cur_addr", bus.cur_addr, x.addr);
        chk("cur_valid", bus.cur_valid, 1);
        chk("busy_end", bus.busy, 0);
        chk("model_count", model, x.addr);
        chk("inc_pulses", rises - x.rise0, x.n);
        chk("rst_low_cycles", rst_low - x.rlow0, x.rlow);
        chk("pulse_width", width_bad - x.wbad0, 0);
        chk("ena_during_activity", ena_bad - x.ebad0, 0);
        m_cur = x.addr;
        m_valid = 1'b1;
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        int k;
        exp_t dropped;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_ena   = 1'b0;
        #23;
        chk("rst_rstn", ctrl_sel_rst_n, 0);
        chk("rst_inc", ctrl_sel_inc, 0);
        chk("rst_ena", ctrl_ena, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cur_valid", bus.cur_valid, 0);
        chk("rst_cur_addr", bus.cur_addr, 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_rstn", ctrl_sel_rst_n, 0);
        chk("idle_inc", ctrl_sel_inc, 0);
        chk("idle_ena", ctrl_ena, 0);
        chk("idle_ready", bus.req_ready, 1);
        chk("idle_cur_valid", bus.cur_valid, 0);
        chk("idle_model", model, 0);

        issue(10'd5, 1'b1);
        finish(1'b0);
        issue(10'h3FF, 1'b0);
        finish(1'b1);
        issue(10'd5, 1'b1);
        finish(1'b0);
        issue(10'd9, 1'b1);
        finish(1'b0);
        issue(10'd9, 1'b1);
        finish(1'b0);
        issue(10'd2, 1'b1);
        finish(1'b0);

        issue(10'd10, 1'b1);
        k = 0;
        while (rises - sb[0].rise0 < 3 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_pulse3_reached", rises - sb[0].rise0, 3);
        chk("abort_inc_high", ctrl_sel_inc, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_inc", ctrl_sel_inc, 0);
        chk("abort_ena", ctrl_ena, 0);
        chk("abort_rstn", ctrl_sel_rst_n, 0);
        chk("abort_ready", bus.req_ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_cur_valid", bus.cur_valid, 0);
        chk("abort_model", model, 0);
        dropped = sb.pop_front();
        m_valid = 1'b0;
        m_cur = '0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(10'd10, 1'b1);
        finish(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
